// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_seq_pkg : shared PC-select codes, op classes and sequencer state codes  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package pc_seq_pkg;

  localparam logic [4:0] PC_INC  = 5'b11111;
  localparam logic [4:0] PC_JUMP = 5'b11110;
  localparam logic [4:0] PC_POP  = 5'b11101;
  localparam logic [4:0] PC_HOLD = 5'b00000;

  typedef enum logic [2:0] {
    OP_SEQ  = 3'b000,
    OP_JMP  = 3'b001,
    OP_JZ   = 3'b010,
    OP_CALL = 3'b011,
    OP_RET  = 3'b100,
    OP_LDST = 3'b101,
    OP_RSVD = 3'b110,
    OP_HALT = 3'b111
  } op_class_e;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_BOOT     = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH    = 3'd1;
  localparam logic [STATE_W-1:0] ST_DECODE   = 3'd2;
  localparam logic [STATE_W-1:0] ST_EXEC_JMP = 3'd3;
  localparam logic [STATE_W-1:0] ST_DATA     = 3'd4;
  localparam logic [STATE_W-1:0] ST_HALT     = 3'd5;

  // Unconditional jumps and taken JZ share the EXEC_JMP path.
  function automatic logic jump_taken(input op_class_e op, input logic cond);
    return (op == OP_JMP) || ((op == OP_JZ) && cond);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_sequencer_if : decoder / memory / PC datapath signals of the sequencer  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface pc_sequencer_if #(
  parameter int ADDR_W = 8
) ();

  logic [ADDR_W-1:0] pc_in;
  logic              mem_ready;
  logic [2:0]        op_class;
  logic              cond;
  logic [ADDR_W-1:0] target;

  logic              mem_req;
  logic              mem_sel;
  logic              ir_load;
  logic [4:0]        pc_cs;
  logic [ADDR_W-1:0] pila;
  logic [ADDR_W-1:0] pcontrol;
  logic              stack_err;
  logic              halted;

  // master: the surrounding datapath/decoder; slave: the sequencer itself
  modport master (
    output pc_in, mem_ready, op_class, cond, target,
    input  mem_req, mem_sel, ir_load, pc_cs, pila, pcontrol, stack_err, halted
  );

  modport slave (
    input  pc_in, mem_ready, op_class, cond, target,
    output mem_req, mem_sel, ir_load, pc_cs, pila, pcontrol, stack_err, halted
  );

endinterface
`default_nettype wire

// File: rtl/pc_sequencer_ret_stack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ret_stack : LIFO of return addresses, no wrap, top reads 0 when empty      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ret_stack #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  logic [SP_W-1:0]   sp;
  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              do_push;
  logic              do_pop;

  assign full    = (sp == SP_W'(STACK_DEPTH));
  assign empty   = (sp == '0);
  assign wr_idx  = sp[IDX_W-1:0];
  assign rd_idx  = IDX_W'(sp - SP_W'(1));

  // Refuse writes past full and reads past empty so sp never wraps.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + SP_W'(1);
    end else if (do_pop) begin
      sp <= sp - SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= din;
    end
  end

  assign top = empty ? '0 : mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_sequencer : fetch/decode/execute FSM, PC select, return stack, mem arb  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  logic [ADDR_W-1:0]  pcontrol;
  logic               stack_err;

  op_class_e          op;
  logic               in_decode;
  logic               push;
  logic               pop;
  logic               err_set;
  logic               full;
  logic               empty;
  logic [ADDR_W-1:0]  top;

  logic               mem_req;
  logic               mem_sel;
  logic               ir_load;
  logic [4:0]         pc_cs;
  logic               halted;

  assign op        = op_class_e'(bus.op_class);
  assign in_decode = (state == ST_DECODE);

  // pc_in already points past the CALL, so it is the return address.
  assign push    = in_decode && (op == OP_CALL) && !full;
  assign pop     = in_decode && (op == OP_RET) && !empty;
  assign err_set = in_decode && (((op == OP_CALL) && full) || ((op == OP_RET) && empty));

  ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.pc_in),
    .top   (top),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT:     state_next = ST_FETCH;
      ST_FETCH:    if (bus.mem_ready) state_next = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_JMP, OP_JZ: state_next = jump_taken(op, bus.cond) ? ST_EXEC_JMP : ST_FETCH;
          OP_CALL:       state_next = full ? ST_HALT : ST_EXEC_JMP;
          OP_RET:        state_next = empty ? ST_HALT : ST_FETCH;
          OP_LDST:       state_next = ST_DATA;
          OP_HALT:       state_next = ST_HALT;
          default:       state_next = ST_FETCH;
        endcase
      end
      ST_EXEC_JMP: state_next = ST_FETCH;
      ST_DATA:     if (bus.mem_ready) state_next = ST_FETCH;
      ST_HALT:     state_next = ST_HALT;
      default:     state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_BOOT;
      pcontrol  <= '0;
      stack_err <= 1'b0;
    end else begin
      state <= state_next;
      if (in_decode) begin
        pcontrol <= bus.target;
      end
      if (err_set) begin
        stack_err <= 1'b1;
      end
    end
  end

  // Moore decode, except the fetch handshake and the RET pop in DECODE.
  always_comb begin
    mem_req = 1'b0;
    mem_sel = 1'b0;
    ir_load = 1'b0;
    pc_cs   = PC_HOLD;
    halted  = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_load = 1'b1;
          pc_cs   = PC_INC;
        end
      end
      ST_DECODE: begin
        if (pop) begin
          pc_cs = PC_POP;
        end
      end
      ST_EXEC_JMP: pc_cs = PC_JUMP;
      ST_DATA: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_sel   = mem_sel;
  assign bus.ir_load   = ir_load;
  assign bus.pc_cs     = pc_cs;
  assign bus.pila      = top;
  assign bus.pcontrol  = pcontrol;
  assign bus.stack_err = stack_err;
  assign bus.halted    = halted;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pc_sequencer : directed + random instruction streams vs. an ISA model   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  pc_sequencer #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Program counter register of the datapath, steered by pc_cs.
  logic [ADDR_W-1:0] pc;
  always @(posedge clk or posedge reset) begin
    if (reset) pc <= '0;
    else begin
      case (bus.pc_cs)
        5'b11111: pc <= pc + 8'd1;
        5'b11110: pc <= bus.pcontrol;
        5'b11101: pc <= bus.pila;
        default:  pc <= pc;
      endcase
    end
  end
  assign bus.pc_in = pc;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Instruction-level reference: PC, return-address LIFO, error and halt flags.
  logic [ADDR_W-1:0] ref_pc;
  logic [ADDR_W-1:0] ref_stk[$];
  bit                ref_err;
  bit                ref_halted;

  function automatic logic [ADDR_W-1:0] ref_top();
    return (ref_stk.size() == 0) ? '0 : ref_stk[ref_stk.size()-1];
  endfunction

  task automatic ref_clear();
    ref_pc = '0;
    ref_stk.delete();
    ref_err = 1'b0;
    ref_halted = 1'b0;
  endtask

  task automatic check_boot();
    check("boot_req", bus.mem_req, 0);
    check("boot_cs", bus.pc_cs, PC_HOLD);
    check("boot_irl", bus.ir_load, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.mem_ready = $urandom_range(0, 1);
    #1;
    check("rst_req", bus.mem_req, 0);
    check("rst_sel", bus.mem_sel, 0);
    check("rst_cs", bus.pc_cs, PC_HOLD);
    check("rst_halt", bus.halted, 0);
    check("rst_err", bus.stack_err, 0);
    check("rst_pctl", bus.pcontrol, 0);
    check("rst_pila", bus.pila, 0);
    @(negedge clk);
    reset = 1'b0;
    ref_clear();
    #1;
    check_boot();
  endtask

  task automatic fetch_phase(input int lat);
    for (int i = 0; i <= lat; i++) begin
      @(negedge clk);
      bus.mem_ready = (i == lat);
      #1;
      check("f_req", bus.mem_req, 1);
      check("f_sel", bus.mem_sel, 0);
      check("f_irl", bus.ir_load, (i == lat));
      check("f_cs", bus.pc_cs, (i == lat) ? PC_INC : PC_HOLD);
      if (i == 0) begin
        check("f_pc", bus.pc_in, ref_pc);
        check("f_pila", bus.pila, ref_top());
        check("f_err", bus.stack_err, ref_err);
      end
    end
    ref_pc = ref_pc + 8'd1;
  endtask

  task automatic decode_phase(input logic [2:0] op, input logic [ADDR_W-1:0] tgt,
                              input logic cnd, input int lat, input bit abort);
    bit jump = 1'b0;
    bit data = 1'b0;
    @(negedge clk);
    bus.mem_ready = $urandom_range(0, 1);
    bus.op_class  = op;
    bus.target    = tgt;
    bus.cond      = cnd;
    #1;
    check("d_req", bus.mem_req, 0);
    check("d_irl", bus.ir_load, 0);
    if (op == OP_RET && ref_stk.size() != 0) begin
      check("d_pila", bus.pila, ref_top());
      check("d_cs", bus.pc_cs, PC_POP);
    end else begin
      check("d_cs", bus.pc_cs, PC_HOLD);
    end

    case (op)
      OP_JMP:  jump = 1'b1;
      OP_JZ:   jump = cnd;
      OP_CALL: begin
        if (ref_stk.size() == DEPTH) begin
          ref_err = 1'b1;
          ref_halted = 1'b1;
        end else begin
          ref_stk.push_back(ref_pc);
          jump = 1'b1;
        end
      end
      OP_RET: begin
        if (ref_stk.size() == 0) begin
          ref_err = 1'b1;
          ref_halted = 1'b1;
        end else begin
          ref_pc = ref_stk.pop_back();
        end
      end
      OP_LDST: data = 1'b1;
      OP_HALT: ref_halted = 1'b1;
      default: ;
    endcase

    if (jump) begin
      @(negedge clk);
      bus.mem_ready = $urandom_range(0, 1);
      #1;
      check("x_cs", bus.pc_cs, PC_JUMP);
      check("x_pctl", bus.pcontrol, tgt);
      check("x_req", bus.mem_req, 0);
      check("x_irl", bus.ir_load, 0);
      ref_pc = tgt;
    end

    if (data) begin
      for (int i = 0; i <= lat; i++) begin
        @(negedge clk);
        bus.mem_ready = (i == lat);
        if (abort && i == 1) begin
          reset = 1'b1;
          #1;
          check("a_req", bus.mem_req, 0);
          check("a_sel", bus.mem_sel, 0);
          @(negedge clk);
          reset = 1'b0;
          bus.mem_ready = 1'b0;
          ref_clear();
          #1;
          check_boot();
          return;
        end
        #1;
        check("m_req", bus.mem_req, 1);
        check("m_sel", bus.mem_sel, 1);
        check("m_cs", bus.pc_cs, PC_HOLD);
        check("m_irl", bus.ir_load, 0);
      end
    end

    if (ref_halted) begin
      repeat (3) begin
        @(negedge clk);
        bus.mem_ready = $urandom_range(0, 1);
        #1;
        check("h_halt", bus.halted, 1);
        check("h_req", bus.mem_req, 0);
        check("h_cs", bus.pc_cs, PC_HOLD);
        check("h_irl", bus.ir_load, 0);
        check("h_err", bus.stack_err, ref_err);
        check("h_pc", bus.pc_in, ref_pc);
      end
    end
  endtask

  task automatic instr(input logic [2:0] op, input logic [ADDR_W-1:0] tgt,
                       input logic cnd, input int flat, input int dlat);
    fetch_phase(flat);
    decode_phase(op, tgt, cnd, dlat, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int r;
    logic [2:0] op;
    bus.mem_ready = 1'b0;
    bus.op_class  = '0;
    bus.target    = '0;
    bus.cond      = 1'b0;
    ref_clear();

    // sequential stream
    do_reset();
    repeat (3) instr(OP_SEQ, 8'h00, 1'b0, 1, 0);

    // JMP then untaken JZ
    instr(OP_JMP, 8'h40, 1'b0, 1, 0);
    instr(OP_JZ, 8'h80, 1'b0, 1, 0);
    instr(OP_JZ, 8'h10, 1'b1, 0, 0);
    instr(OP_SEQ, 8'h00, 1'b0, 0, 0);

    // CALL at 0x05, RET back to 0x06
    do_reset();
    instr(OP_JMP, 8'h05, 1'b0, 1, 0);
    instr(OP_CALL, 8'h20, 1'b0, 1, 0);
    instr(OP_RET, 8'h00, 1'b0, 1, 0);
    instr(OP_SEQ, 8'h00, 1'b0, 1, 0);

    // overflow on the fifth nested CALL
    do_reset();
    for (int k = 1; k <= 5; k++) instr(OP_CALL, 8'(k * 16), 1'b0, 1, 0);

    // underflow on RET with an empty stack
    do_reset();
    instr(OP_RET, 8'h00, 1'b0, 1, 0);

    // data access with a 3-cycle memory delay
    do_reset();
    instr(OP_LDST, 8'h00, 1'b0, 1, 3);
    instr(OP_SEQ, 8'h00, 1'b0, 1, 0);

    // reset while waiting on a data access
    do_reset();
    instr(OP_SEQ, 8'h00, 1'b0, 0, 0);
    fetch_phase(0);
    decode_phase(OP_LDST, 8'h00, 1'b0, 3, 1'b1);
    instr(OP_SEQ, 8'h00, 1'b0, 1, 0);

    // random instruction streams
    do_reset();
    repeat (200) begin
      if (ref_halted) do_reset();
      r = $urandom_range(0, 19);
      if      (r < 4)  op = OP_SEQ;
      else if (r < 6)  op = OP_JMP;
      else if (r < 9)  op = OP_JZ;
      else if (r < 12) op = OP_CALL;
      else if (r < 15) op = OP_RET;
      else if (r < 17) op = OP_LDST;
      else if (r < 18) op = OP_RSVD;
      else if (r < 19) op = OP_HALT;
      else             op = OP_SEQ;
      instr(op, 8'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
